// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NUM_REQ writers into one downstream FIFO.
// Defining FIFO_ARB_STATS_EN adds stall_cnt, a saturating count of fifo_full stall cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    input  logic [NUM_REQ-1:0]            last,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wdata
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, rr_q, rr_d;
    logic [3:0]    beat_q, beat_d;
    logic          found;
    logic          burst_end;
    assign fifo_wr    = (state_q == BURST) && req[owner_q] && !fifo_full;
    assign gnt        = fifo_wr ? NUM_REQ'(1) << owner_q : '0;
    assign fifo_wdata = din[owner_q*DATA_WIDTH +: DATA_WIDTH];
    // A dropped request ends the burst even while the FIFO is full.
    assign burst_end  = !req[owner_q] || (fifo_wr && (last[owner_q] || beat_q + 4'd1 == 4'(BURST_MAX)));
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = fifo_wr ? beat_q + 4'd1 : beat_q;
        found   = 1'b0;
        if (state_q == IDLE) begin
            for (int k = 1; k <= NUM_REQ; k++)
                if (!found && req[(int'(rr_q) + k) % NUM_REQ]) begin
                    found   = 1'b1;
                    owner_d = IW'((int'(rr_q) + k) % NUM_REQ);
                end
            if (found) begin
                state_d = BURST;
                beat_d  = '0;
            end
        end else if (burst_end) begin
            state_d = IDLE;
            rr_d    = owner_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_q;
    assign stall_cnt = stall_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            stall_q <= '0;
        else if (state_q == BURST && req[owner_q] && fifo_full && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus against a cycle-level reference of the arbiter rules.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req, last, gnt;
    logic [N*DW-1:0] din;
    logic          fifo_full, fifo_wr;
    logic [DW-1:0] fifo_wdata;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]   stall_cnt;
`endif
    int compared = 0;
    int mismatched = 0;
    // reference: busy flag, owner, words written this burst, last winner, stall total
    bit m_busy;
    int m_sel, m_words, m_prev, m_stall;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .din(din), .last(last),
        .fifo_full(fifo_full), .gnt(gnt), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata)
`ifdef FIFO_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_words = 0; m_prev = N - 1; m_stall = 0;
    endtask

    task automatic check_outputs();
        bit w;
        w = m_busy && req[m_sel] && !fifo_full;
        chk("fifo_wr", 32'(fifo_wr), 32'(w));
        chk("gnt", 32'(gnt), w ? 32'(1) << m_sel : 32'd0);
        chk("wdata", 32'(fifo_wdata), 32'(din[m_sel*DW +: DW]));
`ifdef FIFO_ARB_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic model_step();
        bit w;
        w = m_busy && req[m_sel] && !fifo_full;
        if (m_busy) begin
            if (req[m_sel] && fifo_full && m_stall < 16'hFFFF) m_stall++;
            if (w) m_words++;
            if (!req[m_sel] || (w && (last[m_sel] || m_words == BM))) begin
                m_busy = 0;
                m_prev = m_sel;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++)
                if (!m_busy && req[(m_prev + k) % N]) begin
                    m_busy = 1;
                    m_sel = (m_prev + k) % N;
                end
            m_words = 0;
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        req = r; last = l; fifo_full = f; din = $urandom;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic hard_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        reset_n = 1'b0; req = '0; last = '0; fifo_full = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 req = 4'b1111; din = 32'hA1B2C3D4;
        #1 chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'hD4);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (12) cycle(4'b0001, 4'b0000, 1'b0);
        hard_reset();
        repeat (25) cycle(4'b1111, 4'b0000, 1'b0);
        hard_reset();
        repeat (2) cycle(4'b0100, 4'b0000, 1'b0);
        repeat (10) cycle(4'b0100, 4'b0000, 1'b1);
        repeat (4) cycle(4'b0100, 4'b0000, 1'b0);
`ifdef FIFO_ARB_STATS_EN
        chk("stall_total", 32'(stall_cnt), 32'd10);
`endif
        hard_reset();
        repeat (2) cycle(4'b0011, 4'b0001, 1'b0);
        repeat (4) cycle(4'b0011, 4'b0000, 1'b0);
        hard_reset();
        repeat (3) cycle(4'b0101, 4'b0000, 1'b0);
        repeat (4) cycle(4'b0100, 4'b0000, 1'b0);
        hard_reset();
        repeat (5) cycle(4'b1111, 4'b0000, 1'b0);
        repeat (3) cycle(4'b1110, 4'b0000, 1'b0);
        req = 4'b1110; din = $urandom;
        #2 reset_n = 1'b0;
        #1 chk("async_wr", 32'(fifo_wr), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_wdata", 32'(fifo_wdata), 32'(din[DW-1:0]));
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) cycle(4'b1111, 4'b0000, 1'b0);
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 5 == 0) r = N'($urandom);
            cycle(r, ($urandom % 4 == 0) ? N'($urandom) : '0, $urandom % 4 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum words per grant, 1..15.
REQ-004 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, NUM_REQ: per-requester write request, level held while data pending.
REQ-007 SHALL have port din, input, NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port last, input, NUM_REQ: requester i marks its current word as final word of burst.
REQ-009 SHALL have port fifo_full, input, 1: full flag of downstream FIFO.
REQ-010 SHALL have port gnt, output, NUM_REQ: one-hot pulse, word of requester i accepted this cycle.
REQ-011 SHALL have port fifo_wr, output, 1: FIFO write strobe.
REQ-012 SHALL have port fifo_wdata, output, DATA_WIDTH: FIFO write data.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and BURST, plus registered owner index, round-robin pointer rr_ptr and beat counter beat_cnt (4 bits).
REQ-014 IDLE: if any req bit set, SHALL select owner = first set bit searching from rr_ptr+1 upward modulo NUM_REQ, clear beat_cnt, go to BURST next cycle; else stay IDLE.
REQ-015 SHALL assert fifo_wr combinationally = (state==BURST) & req[owner] & ~fifo_full.
REQ-016 SHALL drive fifo_wdata = din slice of owner in all states; gnt = one-hot(owner) when fifo_wr, else all zero.
REQ-017 SHALL increment beat_cnt on each fifo_wr cycle only; fifo_full stall cycles SHALL NOT count.
REQ-018 BURST SHALL end (go IDLE next cycle, rr_ptr <= owner) on: fifo_wr with last[owner]=1; or fifo_wr with beat_cnt+1 == BURST_MAX; or req[owner]=0.
REQ-019 Otherwise BURST SHALL hold owner, including indefinitely while fifo_full=1.
REQ-020 Arbitration latency SHALL be one IDLE cycle between consecutive bursts; first write no earlier than 2 cycles after req rises from IDLE.
REQ-021 Requests of non-owners during BURST SHALL be ignored and never produce gnt or fifo_wr.
REQ-022 At most one gnt bit and at most one FIFO write SHALL occur per cycle.
REQ-023 Single active requester SHALL be re-granted after each IDLE cycle (round robin degenerates to it).

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, owner=0, rr_ptr=NUM_REQ-1 (so requester 0 first priority), beat_cnt=0.
REQ-025 During and after reset: fifo_wr=0, gnt=0; fifo_wdata = din slice 0.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no partial write on that or later cycles; no history retained.

Configuration
REQ-027 Macro FIFO_ARB_STATS_EN defined SHALL add output stall_cnt[15:0]: counts cycles with state==BURST & req[owner] & fifo_full, saturates at 16'hFFFF, reset to 0.
REQ-028 Macro undefined SHALL omit stall_cnt port and counter; all other behaviour identical.

Verification
REQ-029 Reset then req=4'b0001, last never, fifo_full=0 -> first fifo_wr cycle 2, 4 writes (BURST_MAX), 1 idle cycle, repeat.
REQ-030 req=4'b1111 held, no last -> bursts granted in order 0,1,2,3,0, each 4 words, gnt one-hot matches fifo_wdata source.
REQ-031 Owner 2 mid-burst after 1 word, fifo_full=1 for 10 cycles -> no fifo_wr/gnt, owner stays 2, then 3 more words; stall_cnt=10 with FIFO_ARB_STATS_EN.
REQ-032 req=4'b0011, last[0]=1 on first word -> requester 0 gets 1 word, requester 1 granted next.
REQ-033 Owner drops req after 2 words -> IDLE next cycle, rr_ptr=owner, next owner is next set bit.
REQ-034 reset_n low for 1 cycle during burst word 3 -> fifo_wr 0 asynchronously, after release requester 0 has priority.
